// File: rtl/audio_dc_filter_pkg.sv
// Shared audio definitions: sample widths, the DC tracker mid-scale preload
// and a 17-to-16-bit signed saturation helper.
package audio_dc_filter_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int PSG_W     = 10;
    localparam int MID_LEVEL = 16368;
    localparam logic AUDIO_S = 1'b1;

    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        logic signed [15:0] r;
        if (v[16] != v[15]) begin
            r = v[16] ? 16'sh8000 : 16'sh7FFF;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/audio_dc_filter_strobe_gen.sv
// Fixed-rate divider: ce_o is high for one clock every DIV clocks, reusable
// by any audio path that resamples at a constant strobe rate.
module audio_strobe_gen #(
    parameter int DIV = 667
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic ce_o
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count wraps to zero after the last divider state.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        ce_o  = 1'b0;
        if (cnt_q == LAST) begin
            cnt_d = '0;
            ce_o  = 1'b1;
        end else begin
            ce_o  = 1'b0;
        end
    end

    // Divider counter register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/audio_dc_filter.sv
// PSG audio output stage: resample on a fixed strobe, remove DC with a
// tracking accumulator, smooth with a one-pole low-pass, drive signed L/R.
module audio_dc_filter
    import audio_dc_filter_pkg::*;
#(
    parameter int SAMPLE_DIV = 667,
    parameter int DC_SHIFT   = 8,
    parameter int LP_SHIFT   = 2
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                mute,
    input  logic [PSG_W-1:0]    sound_in,
    output logic [SAMPLE_W-1:0] out_l,
    output logic [SAMPLE_W-1:0] out_r,
    output logic                sample_stb
);

    localparam int ACC_W = 17 + DC_SHIFT;
    localparam logic signed [ACC_W-1:0] ACC_INIT = ACC_W'(MID_LEVEL) << DC_SHIFT;

    logic                    ce_s;
    logic                    v1_q, v2_q, v3_q, stb_q;
    logic signed [15:0]      x_q, hp_q, lp_q, out_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [16:0]      dc_s, diff_s, lp_diff_s;
    logic signed [15:0]      lp_step_s, hp_d, lp_d;

    audio_strobe_gen #(
        .DIV (SAMPLE_DIV)
    ) u_strobe (
        .clk_i   (clk_sys),
        .reset_i (reset),
        .ce_o    (ce_s)
    );

    // High-pass and low-pass next-state arithmetic; dc always fits 17 bits
    // because the tracker follows an input bounded to 0..32736.
    always_comb begin
        dc_s      = 17'(acc_q >>> DC_SHIFT);
        diff_s    = {x_q[15], x_q} - dc_s;
        acc_d     = acc_q + {{(ACC_W-17){diff_s[16]}}, diff_s};
        hp_d      = sat16(diff_s);
        lp_diff_s = {hp_q[15], hp_q} - {lp_q[15], lp_q};
        lp_step_s = 16'(lp_diff_s >>> LP_SHIFT);
        if (LP_SHIFT == 0) begin
            lp_d = hp_q;
        end else begin
            lp_d = lp_q + lp_step_s;
        end
    end

    // Four-stage single-sample pipeline; each stage moves only on its valid bit.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            stb_q <= 1'b0;
            x_q   <= 16'sd0;
            acc_q <= ACC_INIT;
            hp_q  <= 16'sd0;
            lp_q  <= 16'sd0;
            out_q <= 16'sd0;
        end else begin
            v1_q  <= ce_s;
            v2_q  <= v1_q;
            v3_q  <= v2_q;
            stb_q <= v3_q;
            if (ce_s) begin
                x_q <= {1'b0, sound_in, 5'b00000};
            end
            if (v1_q) begin
                acc_q <= acc_d;
                hp_q  <= hp_d;
            end
            if (v2_q) begin
                lp_q <= lp_d;
            end
            if (v3_q) begin
                out_q <= mute ? 16'sd0 : lp_q;
            end
        end
    end

    assign out_l      = out_q;
    assign out_r      = out_q;
    assign sample_stb = stb_q;

endmodule

// File: tb/tb_audio_dc_filter.sv
// Self-checking bench for audio_dc_filter against an integer reference model.
module tb_audio_dc_filter;

    localparam int SD  = 8;
    localparam int DCS = 4;
    localparam int LPS = 2;

    logic        clk_sys  = 1'b0;
    logic        reset    = 1'b1;
    logic        mute     = 1'b0;
    logic [9:0]  sound_in = 10'd0;
    logic [15:0] out_l;
    logic [15:0] out_r;
    logic        sample_stb;

    int          n_tests = 0;
    int          n_fail  = 0;
    longint      m_acc;
    longint      m_lp;
    logic [15:0] prev_out;
    logic [15:0] y;

    always #5 clk_sys = ~clk_sys;

    audio_dc_filter #(
        .SAMPLE_DIV (SD),
        .DC_SHIFT   (DCS),
        .LP_SHIFT   (LPS)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .mute       (mute),
        .sound_in   (sound_in),
        .out_l      (out_l),
        .out_r      (out_r),
        .sample_stb (sample_stb)
    );

    // Division rounding toward minus infinity by 2^k.
    function automatic longint fdiv(input longint v, input int k);
        longint p;
        p = longint'(1) << k;
        if (v >= 0) return v / p;
        else return -((-v + p - 1) / p);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic model_reset();
        m_acc    = longint'(16368) << DCS;
        m_lp     = 0;
        prev_out = 16'd0;
    endtask

    task automatic model_step(input int level, input bit m, output logic [15:0] r);
        longint x, d, hp;
        x  = longint'(level) * 32;
        d  = x - fdiv(m_acc, DCS);
        hp = (d > 32767) ? 32767 : ((d < -32768) ? -32768 : d);
        m_acc = m_acc + d;
        if (LPS == 0) m_lp = hp;
        else m_lp = m_lp + fdiv(hp - m_lp, LPS);
        r = m ? 16'd0 : 16'(m_lp);
    endtask

    // Drives one sample; sound_in is valid only in the ce cycle, junk otherwise.
    task automatic run_sample(input int level, input bit m, input bit after_reset,
                              input string tag, output logic [15:0] r);
        int pre;
        int n;
        logic [15:0] e;
        pre = after_reset ? SD - 1 : SD - 4;
        n   = pre + 4;
        model_step(level, m, r);
        mute = m;
        for (int i = 1; i <= n; i++) begin
            sound_in = (i == pre + 1) ? level[9:0] : 10'($urandom_range(0, 1023));
            @(posedge clk_sys);
            #1;
            e = (i == n) ? r : prev_out;
            check({tag, "/stb"}, {15'd0, sample_stb}, {15'd0, (i == n)});
            check({tag, "/l"}, out_l, e);
            check({tag, "/r"}, out_r, e);
        end
        prev_out = r;
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_l", out_l, 16'd0);
        check("rst_r", out_r, 16'd0);
        check("rst_stb", {15'd0, sample_stb}, 16'd0);
        reset = 1'b0;
        model_reset();

        run_sample(512, 1'b0, 1'b1, "first", y);
        check("first_val", out_l, 16'd4);
        for (int k = 0; k < 159; k++) run_sample(512, 1'b0, 1'b0, "hold512", y);
        check("decay_zero", out_l, 16'd0);

        run_sample(1023, 1'b0, 1'b0, "step", y);
        check("step_val", out_l, 16'd4088);
        for (int k = 0; k < 30; k++) run_sample(1023, 1'b0, 1'b0, "hold1023", y);

        for (int k = 0; k < 40; k++)
            run_sample(int'($urandom_range(0, 1023)), bit'($urandom_range(0, 1)), 1'b0, "rand", y);

        for (int k = 0; k < 64; k++) run_sample(0, 1'b0, 1'b0, "drain", y);
        for (int k = 0; k < 20; k++) begin
            run_sample(1023, 1'b0, 1'b0, "sat", y);
            check("sat_nowrap", {15'd0, out_l[15]}, 16'd0);
        end

        for (int k = 0; k < 10; k++) begin
            run_sample((k % 2 == 0) ? 0 : 1023, 1'b1, 1'b0, "mute", y);
            check("mute_zero", out_l, 16'd0);
        end
        for (int k = 0; k < 10; k++) run_sample((k % 2 == 0) ? 0 : 1023, 1'b0, 1'b0, "unmute", y);

        // Reset lands one cycle after the ce edge of an in-flight sample.
        mute = 1'b0;
        for (int i = 1; i <= SD - 3; i++) begin
            sound_in = (i == SD - 3) ? 10'd700 : 10'($urandom_range(0, 1023));
            @(posedge clk_sys);
            #1;
            check("pre_rst_stb", {15'd0, sample_stb}, 16'd0);
        end
        reset = 1'b1;
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        model_reset();
        check("midrst_l", out_l, 16'd0);
        check("midrst_r", out_r, 16'd0);
        check("midrst_stb", {15'd0, sample_stb}, 16'd0);
        run_sample(512, 1'b0, 1'b1, "post_rst", y);
        check("post_rst_val", out_l, 16'd4);
        for (int k = 0; k < 10; k++) run_sample(512, 1'b0, 1'b0, "tail", y);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
